timer_arbiter: RTL and testbench
================================

# timer_arbiter

Round-robin arbiter that shares one 3-bit up-counter timer among NREQ requesters. Each requester asks for a timed slot of length `len`. The arbiter grants one owner at a time, runs the counter from 0 up to that owner's length, and pulses `done` back to the owner. It sits between the client blocks and the counter datapath and owns the counter's clear/enable sequencing.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 3, counter and length width in bits
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous assertion, active-low
- req  in  NREQ  request vector; req[i] is held high by requester i until its done or until it abandons
- len  in  NREQ*WIDTH  packed slot lengths; requester i uses len[i*WIDTH +: WIDTH], sampled only at grant
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-hot completion pulse, one cycle, registered
- busy  out  1  high whenever state is not IDLE
- count  out  WIDTH  current timer value

## Operation
- State machine has three states: IDLE, RUN and DONE.
- Internal registers:
  - `ptr`: round-robin start index, log2 NREQ bits.
  - `owner`: index of the current grant.
  - `target`: latched length, WIDTH bits.
- IDLE behaviour:
  - If any req bit is high, select the first set bit searching from ptr upward, wrapping modulo NREQ.
  - Then set gnt[owner]=1, count=0, target=len[owner], and go to RUN.
  - If no req bit is high, stay in IDLE with count held at 0.
- RUN behaviour, evaluated in priority order:
  - If req[owner]=0, the request is aborted. Go to IDLE, clear gnt and count, do not pulse done, and set ptr=owner+1.
  - Else if count==target, go to DONE and assert done[owner].
  - Otherwise count increments by 1.
- DONE behaviour:
  - done deasserts. gnt, count and done all clear.
  - Set ptr=owner+1 mod NREQ and go to IDLE.
- count never wraps: target ≤ 2^WIDTH−1, so the RUN exit at count==target precedes overflow.
- len changes after grant are ignored. len of a non-granted requester is don't-care.
- A requester that keeps req high after its done is re-arbitrated normally. ptr has moved past it, so it gets the lowest priority.
- gnt and done are always one-hot or zero. done[i] is asserted only while gnt[i] is asserted.

## Timing
- Reset (clr low), effective immediately and asynchronously:
  - state=IDLE, gnt=0, done=0, busy=0, count=0, ptr=0, owner=0, target=0.
- Grant latency: req sampled high at edge k in IDLE gives gnt and busy high after edge k, with count=0.
- Count sequence: count=n after edge k+n, for n=0..len.
- Completion: done is high after edge k+len+1, for exactly one cycle.
- Release: gnt and busy drop after edge k+len+2.
- gnt occupancy is len+2 cycles.
- Minimum spacing between grants is one IDLE cycle. The earliest next grant comes after edge k+len+3.
- Abort: req[owner] low sampled at edge m in RUN gives gnt=0, busy=0, count=0 after edge m.
- Simultaneous req drop and count==target: the abort wins and no done is pulsed.
- Reset asserted mid-RUN or in DONE loses the slot silently; no done is pulsed.

## Test plan
- Reset: pull clr low during RUN with count=2. Required: gnt, done, busy and count are all 0 immediately. After release, req=0001 is granted to requester 0 first.
- Single slot: req=0001, len0=3. Required: gnt=0001 one cycle later; count 0,1,2,3; done=0001 in the 5th gnt cycle; gnt=0000 the next cycle.
- Fairness: all four req high from reset, all len=1, req held continuously. Required: grants go 0,1,2,3,0,1,… with each gnt lasting 3 cycles and one IDLE cycle between grants.
- Pointer: after completing requester 2, assert req=1010. Required: requester 3 is granted before requester 1.
- Abort: len0=5, drop req[0] when count=2. Required: gnt=0000 and count=0 next cycle, no done pulse; the next grant searches from index 1.
- Length bounds:
  - len=0: done asserts in the 2nd gnt cycle and count stays 0.
  - len=7: count reaches 7 without wrap; done asserts in the 9th gnt cycle.
  - Changing len0 mid-RUN does not alter the done timing.

Source files
------------

// File: rtl/timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter_if
// Description : Requester-side bundle for timer_arbiter. Carries the request
//               vector, packed slot lengths, grant/done vectors, busy flag
//               and the live counter value.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    // Client side: drives requests and lengths, observes the arbiter
    modport master (
        output req,
        output len,
        input  gnt,
        input  done,
        input  busy,
        input  count
    );

    // Arbiter side
    modport slave (
        input  req,
        input  len,
        output gnt,
        output done,
        output busy,
        output count
    );
endinterface : timer_arbiter_if
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : Round-robin arbiter sharing one up-counter timer among NREQ
//               requesters. The granted owner's length is latched at grant,
//               the counter runs 0..length, then a one-cycle done pulse is
//               returned and the round-robin pointer moves past the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
) (
    input  wire logic       clk,
    input  wire logic       clr,   // asynchronous, active-low
    timer_arbiter_if.slave  bus
);

    localparam int C_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [C_PW-1:0]   ptr_q,    ptr_d;
    logic [C_PW-1:0]   owner_q,  owner_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  count_q,  count_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [NREQ-1:0]   done_q,   done_d;

    logic              w_found;
    logic [C_PW-1:0]   w_sel;
    logic [C_PW-1:0]   w_idx;
    logic [C_PW-1:0]   w_owner_nxt;
    logic [WIDTH-1:0]  w_len_arr [NREQ];

    // Unpack the per-requester lengths so they can be indexed by owner
    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign w_len_arr[g] = bus.len[g*WIDTH +: WIDTH];
    end

    // Pointer successor of the current owner, wrapping at NREQ
    assign w_owner_nxt = (owner_q == C_PW'(NREQ - 1)) ? '0 : owner_q + C_PW'(1);

    // Round-robin pick: first set request at or after ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = C_PW'((int'(ptr_q) + i) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Next-state and output logic; abort takes priority over completion
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        target_d = target_q;
        count_d  = count_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                gnt_d   = '0;
                if (w_found) begin
                    owner_d      = w_sel;
                    target_d     = w_len_arr[w_sel];
                    gnt_d[w_sel] = 1'b1;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.req[owner_q]) begin
                    // Requester gave up: release silently, no done pulse
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                    ptr_d   = w_owner_nxt;
                end else if (count_q == target_q) begin
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                count_d = '0;
                ptr_d   = w_owner_nxt;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any slot in progress
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            target_q <= '0;
            count_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.count = count_q;

endmodule : timer_arbiter
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Scoreboard bench for timer_arbiter. Stimulus pushes expected
//               grant / done / release events with their cycle stamps; a
//               monitor pops and compares whenever the grant or done vectors
//               change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 3;
    localparam int EV_GNT  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_REL  = 2;

    typedef struct {
        int              kind;
        logic [NREQ-1:0] val;
        int              cyc;
        int              cnt;
    } ev_t;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];

    timer_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: value n seen at a negedge means "after rising edge n"
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [NREQ-1:0] val, input int c, input int cnt);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected event kind %0d: gnt=%b done=%b, expected none (cycle %0d)",
                     kind, bus.gnt, bus.done, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event kind", kind, e.kind);
        check("event cycle", cyc, e.cyc);
        case (kind)
            EV_GNT: begin
                check("grant vector", int'(bus.gnt), int'(e.val));
                check("grant busy", int'(bus.busy), 1);
                check("grant count", int'(bus.count), 0);
            end
            EV_DONE: begin
                check("done vector", int'(bus.done), int'(e.val));
                check("done gnt match", int'(bus.gnt), int'(e.val));
                check("done count", int'(bus.count), e.cnt);
            end
            default: begin
                check("release busy", int'(bus.busy), 0);
                check("release count", int'(bus.count), 0);
            end
        endcase
    endtask

    // Monitor: classify output changes and compare against the scoreboard
    initial begin : mon
        logic [NREQ-1:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (clr === 1'b1) begin
                if (prev_gnt == '0 && bus.gnt != '0)
                    observe(EV_GNT);
                else if (prev_gnt != '0 && bus.gnt == '0)
                    observe(EV_REL);
                else if (prev_gnt != '0 && bus.gnt != prev_gnt)
                    check("grant switch without idle", int'(bus.gnt), int'(prev_gnt));
                if (bus.done != '0)
                    observe(EV_DONE);
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_len(input int idx, input int v);
        bus.len[idx*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // One complete slot for requester idx; optionally rewrite its len after grant
    task automatic slot(input int idx, input int ln, input int chg);
        int k;
        k = cyc + 1;
        set_len(idx, ln);
        bus.req[idx] = 1'b1;
        push(EV_GNT,  NREQ'(1) << idx, k,          0);
        push(EV_DONE, NREQ'(1) << idx, k + ln + 1, ln);
        push(EV_REL,  '0,              k + ln + 2, 0);
        for (int n = 0; n <= ln; n++) begin
            wait_cyc(k + n);
            check($sformatf("slot%0d count step %0d", idx, n), int'(bus.count), n);
            if (n == 1 && chg >= 0) set_len(idx, chg);
        end
        wait_cyc(k + ln + 1);
        check($sformatf("slot%0d count held in done", idx), int'(bus.count), ln);
        bus.req[idx] = 1'b0;
        wait_cyc(k + ln + 2);
    endtask

    initial begin : wdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int k;
        bus.req = '0;
        bus.len = '0;
        clr     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset gnt",   int'(bus.gnt),   0);
        check("reset done",  int'(bus.done),  0);
        check("reset busy",  int'(bus.busy),  0);
        check("reset count", int'(bus.count), 0);
        clr = 1'b1;
        @(negedge clk);

        // Single slot, then length bounds 0 and 7
        slot(0, 3, -1);
        slot(1, 0, -1);
        slot(2, 7, -1);

        // Pointer sits at 3: requester 3 must beat requester 1
        k = cyc + 1;
        set_len(3, 1);
        set_len(1, 2);
        bus.req = 4'b1010;
        push(EV_GNT,  4'b1000, k,     0);
        push(EV_DONE, 4'b1000, k + 2, 1);
        push(EV_REL,  4'b0000, k + 3, 0);
        push(EV_GNT,  4'b0010, k + 4, 0);
        push(EV_DONE, 4'b0010, k + 7, 2);
        push(EV_REL,  4'b0000, k + 8, 0);
        wait_cyc(k + 2);
        bus.req[3] = 1'b0;
        wait_cyc(k + 7);
        bus.req[1] = 1'b0;
        wait_cyc(k + 8);

        // Length rewritten mid-run must not move the done pulse
        slot(2, 2, 6);

        // Abort requester 0 at count 2; next search starts at index 1
        k = cyc + 1;
        set_len(0, 5);
        bus.req = 4'b0001;
        push(EV_GNT, 4'b0001, k,     0);
        push(EV_REL, 4'b0000, k + 3, 0);
        wait_cyc(k + 2);
        check("abort count before drop", int'(bus.count), 2);
        bus.req = 4'b0000;
        wait_cyc(k + 3);
        check("abort count cleared", int'(bus.count), 0);
        k = cyc + 1;
        set_len(2, 1);
        set_len(0, 1);
        bus.req = 4'b0101;
        push(EV_GNT,  4'b0100, k,     0);
        push(EV_DONE, 4'b0100, k + 2, 1);
        push(EV_REL,  4'b0000, k + 3, 0);
        push(EV_GNT,  4'b0001, k + 4, 0);
        push(EV_DONE, 4'b0001, k + 6, 1);
        push(EV_REL,  4'b0000, k + 7, 0);
        wait_cyc(k + 2);
        bus.req[2] = 1'b0;
        wait_cyc(k + 6);
        bus.req[0] = 1'b0;
        wait_cyc(k + 7);

        // Drop coinciding with count==target: abort wins, no done
        k = cyc + 1;
        set_len(1, 2);
        bus.req = 4'b0010;
        push(EV_GNT, 4'b0010, k,     0);
        push(EV_REL, 4'b0000, k + 3, 0);
        wait_cyc(k + 2);
        check("coincide count at target", int'(bus.count), 2);
        bus.req = 4'b0000;
        wait_cyc(k + 4);

        // Reset mid-run at count 2 (pointer is 2 beforehand)
        k = cyc + 1;
        set_len(0, 5);
        bus.req = 4'b0001;
        push(EV_GNT, 4'b0001, k, 0);
        wait_cyc(k + 2);
        check("pre-reset count", int'(bus.count), 2);
        #2 clr = 1'b0;
        #1;
        check("midrun reset gnt",   int'(bus.gnt),   0);
        check("midrun reset done",  int'(bus.done),  0);
        check("midrun reset busy",  int'(bus.busy),  0);
        check("midrun reset count", int'(bus.count), 0);
        @(negedge clk);
        @(negedge clk);

        // Fairness from reset: 0,1,2,3,0,1 with 3-cycle grants and one idle gap
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        bus.req = 4'b1111;
        clr     = 1'b1;
        k = cyc + 1;
        for (int j = 0; j < 6; j++) begin
            push(EV_GNT,  NREQ'(1) << (j % NREQ), k + 4*j,     0);
            push(EV_DONE, NREQ'(1) << (j % NREQ), k + 4*j + 2, 1);
            push(EV_REL,  '0,                     k + 4*j + 3, 0);
        end
        wait_cyc(k + 23);
        bus.req = 4'b0000;
        wait_cyc(k + 27);

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_timer_arbiter
`default_nettype wire
